// File: rtl/spi_pkg.sv
// Shared types, bit-order constants and width helper for the SPI shift register.
package spi_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_bit_cnt.sv
// Bit counter for the SPI shift register; tc flags the last bit of a word.
module spi_bit_cnt
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = clog2(WIDTH);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(WIDTH - 1));

  // Explicit wrap keeps non-power-of-two widths correct.
  always_ff @(posedge CLK) begin
    if (clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/spi_shift_reg.sv
// SPI transmit/receive word register with bit counter and completion pulse.
// Optional per-transfer LSB-first order is enabled by defining SPI_SR_LSB_FIRST_EN.
//
// state    | meaning
// IDLE     | no transfer; LOAD accepted, SHIFT_EN ignored
// SHIFTING | transfer active; SHIFT_EN shifts, LOAD ignored
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             PRE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             SHIFT_EN,
  input  logic             SIN,
  input  logic             LSB_FIRST,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  state_t           state_q;
  state_t           state_d;
  logic             load_go;
  logic             shift_go;
  logic             last_shift;
  logic             tc;
  logic             ord;
  logic [WIDTH-1:0] q_shifted;

  spi_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .CLK (CLK),
    .clr (CLR | PRE | load_go),
    .en  (shift_go),
    .tc  (tc)
  );

  always_ff @(posedge CLK) begin
    if (CLR || PRE)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (LOAD) state_d = SHIFTING;
      SHIFTING: if (SHIFT_EN && tc) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state_q == SHIFTING);
    load_go    = (state_q == IDLE) && LOAD;
    shift_go   = (state_q == SHIFTING) && SHIFT_EN;
    last_shift = shift_go && tc;
  end

`ifdef SPI_SR_LSB_FIRST_EN
  // PRE deliberately leaves the latched order alone.
  always_ff @(posedge CLK) begin
    if (CLR)
      ord <= spi_pkg::MSB_FIRST;
    else if (!PRE && load_go)
      ord <= LSB_FIRST;
  end

  assign q_shifted = (ord == spi_pkg::LSB_FIRST) ? {SIN, Q[WIDTH-1:1]}
                                                 : {Q[WIDTH-2:0], SIN};
  assign SOUT      = (ord == spi_pkg::LSB_FIRST) ? Q[0] : Q[WIDTH-1];
`else
  logic unused_lsb_first;

  assign unused_lsb_first = LSB_FIRST;
  assign ord              = spi_pkg::MSB_FIRST;
  assign q_shifted        = {Q[WIDTH-2:0], SIN};
  assign SOUT             = ord ? Q[0] : Q[WIDTH-1];
`endif

  always_ff @(posedge CLK) begin
    if (CLR)
      Q <= RESET_VAL;
    else if (PRE)
      Q <= '1;
    else if (load_go)
      Q <= DATA;
    else if (shift_go)
      Q <= q_shifted;
  end

  always_ff @(posedge CLK) begin
    if (CLR || PRE)
      DONE <= 1'b0;
    else
      DONE <= last_shift;
  end

endmodule

// File: tb/tb_spi_shift_reg.sv
// Self-checking bench for spi_shift_reg (WIDTH=8): word-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_spi_shift_reg;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       PRE = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] DATA = 8'h00;
  logic       SHIFT_EN = 1'b0;
  logic       SIN = 1'b0;
  logic       LSB_FIRST = 1'b0;
  logic [7:0] Q;
  logic       SOUT;
  logic       BUSY;
  logic       DONE;

  int n_pass = 0;
  int n_total = 0;

  spi_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .PRE       (PRE),
    .LOAD      (LOAD),
    .DATA      (DATA),
    .SHIFT_EN  (SHIFT_EN),
    .SIN       (SIN),
    .LSB_FIRST (LSB_FIRST),
    .Q         (Q),
    .SOUT      (SOUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Word-level model: a transfer is the loaded word plus the SIN bits seen so far.
  int m_q, m_data, m_rx, m_n;
  bit m_busy, m_done, m_ord, m_valid;

  initial begin
    m_q = 0; m_data = 0; m_rx = 0; m_n = 0;
    m_busy = 0; m_done = 0; m_ord = 0; m_valid = 0;
  end

  always @(posedge CLK) begin
    bit moved;
    moved = 0;
    if (CLR) begin
      m_q = 0; m_busy = 0; m_done = 0; m_ord = 0; m_valid = 1;
    end else if (PRE) begin
      m_q = 255; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy && LOAD) begin
        m_data = int'(DATA); m_n = 0; m_rx = 0; m_busy = 1; moved = 1;
`ifdef SPI_SR_LSB_FIRST_EN
        m_ord = LSB_FIRST;
`else
        m_ord = 0;
`endif
      end else if (m_busy && SHIFT_EN) begin
        if (m_ord) m_rx = m_rx | (int'(SIN) << m_n);
        else       m_rx = (m_rx << 1) | int'(SIN);
        m_n++;
        moved = 1;
        if (m_n == 8) begin m_busy = 0; m_done = 1; end
      end
      if (moved)
        m_q = m_ord ? (((m_data >> m_n) | (m_rx << (8 - m_n))) & 255)
                    : (((m_data << m_n) | m_rx) & 255);
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("model_q", int'(Q), m_q);
      chk("model_sout", int'(SOUT), m_ord ? m_q[0] : m_q[7]);
      chk("model_busy", int'(BUSY), int'(m_busy));
      chk("model_done", int'(DONE), int'(m_done));
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic shift_one(input logic b);
    SIN = b; SHIFT_EN = 1'b1; tick(); SHIFT_EN = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] rxw;

    CLR = 1'b1; tick(); CLR = 1'b0;

    // Reset
    PRE = 1'b1; tick(); PRE = 1'b0;
    chk("pre_q", int'(Q), 'hFF);
    CLR = 1'b1; tick(); CLR = 1'b0;
    chk("clr_q", int'(Q), 'h00);
    chk("clr_busy", int'(BUSY), 0);
    chk("clr_done", int'(DONE), 0);
    chk("clr_sout", int'(SOUT), 0);

    // MSB loopback
    pat = 8'hA5;
    DATA = pat; LSB_FIRST = 1'b0; LOAD = 1'b1; tick(); LOAD = 1'b0;
    chk("lb_busy", int'(BUSY), 1);
    for (int i = 0; i < 8; i++) begin
      chk("lb_sout", int'(SOUT), int'(pat[7-i]));
      chk("lb_done_early", int'(DONE), 0);
      shift_one(SOUT);
    end
    chk("lb_q", int'(Q), 'hA5);
    chk("lb_done", int'(DONE), 1);
    chk("lb_busy_fall", int'(BUSY), 0);
    tick();
    chk("lb_done_clear", int'(DONE), 0);

    // Receive with gaps
    rxw = 8'h3C;
    DATA = 8'h00; LOAD = 1'b1; tick(); LOAD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shift_one(rxw[7-i]);
      if (i < 7) begin
        chk("gap_busy", int'(BUSY), 1);
        chk("gap_done", int'(DONE), 0);
        tick();
        chk("gap_busy_idle", int'(BUSY), 1);
      end
    end
    chk("gap_q", int'(Q), 'h3C);
    chk("gap_done_end", int'(DONE), 1);
    tick();

    // Bit order
    DATA = 8'h01; LSB_FIRST = 1'b1; LOAD = 1'b1; tick(); LOAD = 1'b0; LSB_FIRST = 1'b0;
`ifdef SPI_SR_LSB_FIRST_EN
    chk("ord_sout", int'(SOUT), 1);
    shift_one(1'b0);
    chk("ord_q", int'(Q), 'h00);
`else
    chk("ord_sout", int'(SOUT), 0);
    shift_one(1'b0);
    chk("ord_q", int'(Q), 'h02);
`endif
    PRE = 1'b1; tick(); PRE = 1'b0;
    chk("ord_pre_busy", int'(BUSY), 0);

    // CLR beats PRE
    CLR = 1'b1; PRE = 1'b1; tick(); CLR = 1'b0; PRE = 1'b0;
    chk("clrpre_q", int'(Q), 'h00);

    // PRE aborts after 3 shifts
    DATA = 8'hC3; LOAD = 1'b1; tick(); LOAD = 1'b0;
    for (int i = 0; i < 3; i++) shift_one(1'b1);
    PRE = 1'b1; tick(); PRE = 1'b0;
    chk("abort_q", int'(Q), 'hFF);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    tick();
    chk("abort_done_after", int'(DONE), 0);

    // LOAD ignored mid-transfer; count continues from where it was
    DATA = 8'h96; LOAD = 1'b1; tick(); LOAD = 1'b0;
    shift_one(1'b1);
    shift_one(1'b1);
    DATA = 8'h55; LOAD = 1'b1; tick(); LOAD = 1'b0;
    chk("ign_load_q", int'(Q), 'h5B);
    chk("ign_load_busy", int'(BUSY), 1);
    for (int i = 0; i < 6; i++) begin
      shift_one(1'b0);
      chk("ign_cnt_done", int'(DONE), (i == 5) ? 1 : 0);
    end
    chk("ign_final_q", int'(Q), 'hC0);

    // Back-to-back LOAD in DONE cycle, with SHIFT_EN also high (load only)
    DATA = 8'h55; LOAD = 1'b1; SHIFT_EN = 1'b1; SIN = 1'b1; tick();
    LOAD = 1'b0; SHIFT_EN = 1'b0;
    chk("b2b_q", int'(Q), 'h55);
    chk("b2b_busy", int'(BUSY), 1);
    for (int i = 0; i < 8; i++) shift_one(1'b0);
    chk("b2b_done", int'(DONE), 1);
    tick();

    // LOAD + SHIFT_EN from plain idle
    CLR = 1'b1; tick(); CLR = 1'b0;
    DATA = 8'h55; LOAD = 1'b1; SHIFT_EN = 1'b1; tick(); LOAD = 1'b0; SHIFT_EN = 1'b0;
    chk("idle_ldsh_q", int'(Q), 'h55);
    tick();
    SHIFT_EN = 1'b1; SIN = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    SHIFT_EN = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      CLR       = ($urandom_range(0, 63) == 0);
      PRE       = ($urandom_range(0, 31) == 0);
      LOAD      = ($urandom_range(0, 5) == 0);
      SHIFT_EN  = ($urandom_range(0, 1) == 1);
      SIN       = 1'($urandom);
      LSB_FIRST = 1'($urandom);
      DATA      = 8'($urandom);
      tick();
    end
    CLR = 1'b0; PRE = 1'b0; LOAD = 1'b0; SHIFT_EN = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_shift_reg.md
# spi_shift_reg

Parametrised serial/parallel shift register with bit counter and completion flag, for the SPI interface datapath. It generalises the single-bit D flip-flop with clear/preset to a WIDTH-bit word register. The word can be parallel-loaded, shifted through serial in/out, and preset to all ones. It serves as both the SPI transmit and receive register: after WIDTH shifts, the received word sits in Q and DONE pulses.

## Interface
- WIDTH, 8, word length in bits; must be ≥ 2
- RESET_VAL, {WIDTH{1'b0}}, value of Q after CLR
- CLK  in  1  clock; all state updates on rising edge
- CLR  in  1  synchronous, active-high reset
- PRE  in  1  synchronous preset: Q to all ones, abort transfer
- LOAD  in  1  parallel load of DATA and start of transfer
- DATA  in  WIDTH  parallel load word
- SHIFT_EN  in  1  shift one bit this cycle (one SPI bit strobe)
- SIN  in  1  serial input bit
- LSB_FIRST  in  1  bit order, sampled on LOAD (see Configuration)
- Q  out  WIDTH  register contents
- SOUT  out  1  serial output bit, combinational from Q and latched order
- BUSY  out  1  transfer in progress
- DONE  out  1  one-cycle pulse, transfer complete

## Operation
- States: IDLE, SHIFTING. Internal registers: bit counter cnt (width clog2(WIDTH)) and latched order bit ord.
- Per-edge priority, highest first:
  - CLR: Q=RESET_VAL, state IDLE, cnt=0, ord=0, BUSY=0, DONE=0.
  - PRE: Q=all ones, state IDLE, cnt=0, BUSY=0, DONE=0. ord is unchanged.
  - LOAD (IDLE only): Q=DATA, cnt=0, ord=LSB_FIRST, state SHIFTING, BUSY=1.
  - SHIFT_EN (SHIFTING only): shift Q as defined below, cnt=cnt+1.
- Shift rules:
  - MSB-first (ord=0): Q={Q[WIDTH-2:0],SIN}; SOUT=Q[WIDTH-1].
  - LSB-first (ord=1): Q={SIN,Q[WIDTH-1:1]}; SOUT=Q[0].
- Transfer end: a SHIFT_EN with cnt==WIDTH-1 does the last shift. On that same edge: state IDLE, BUSY=0, DONE=1, cnt=0.
- DONE is high for exactly one cycle. It is cleared on the next edge unless another transfer completes on that edge, which is impossible by construction.
- Ignored inputs:
  - LOAD during SHIFTING is ignored; Q and cnt are unaffected.
  - SHIFT_EN during IDLE is ignored; Q holds.
  - LOAD and SHIFT_EN together in IDLE: load only, no shift.
- Gaps in SHIFT_EN during SHIFTING hold all state; BUSY stays 1.
- Reset mid-transfer (CLR or PRE) aborts with no DONE pulse.

## Timing
- Reset values: Q=RESET_VAL, BUSY=0, DONE=0, SOUT=RESET_VAL[WIDTH-1].
- LOAD sampled at edge k: Q=DATA and BUSY=1 are visible after edge k. The first SOUT bit is valid in cycle k+1.
- Each SHIFT_EN edge presents the next SOUT bit after that edge. SIN is captured on the same edge.
- Minimum transfer is WIDTH+1 edges (LOAD plus WIDTH shifts). DONE is asserted the cycle after the final shift edge, coincident with BUSY falling.
- A new LOAD is accepted in the DONE cycle, giving back-to-back words with no idle gap.

## Configuration
- SPI_SR_LSB_FIRST_EN
  - Defined: LSB_FIRST is sampled on LOAD and ord selects the shift direction per transfer.
  - Undefined: ord is tied to 0 and the LSB-first shift path is not synthesised. LSB_FIRST stays in the port list but is ignored; all transfers are MSB-first.

## Structure
- spi_pkg holds:
  - the state enum (IDLE, SHIFTING)
  - bit-order constants MSB_FIRST=0, LSB_FIRST=1
  - function clog2 for the counter width
- One sub-module, spi_bit_cnt: a counter with sync clear, enable, and a terminal-count flag at WIDTH-1. Instantiated once; drives the end-of-transfer condition.

## Test plan
All scenarios use WIDTH=8.
- Reset: Q=0xFF via PRE, then CLR=1 for one edge -> Q=0x00, BUSY=0, DONE=0, SOUT=0.
- MSB loopback: LOAD DATA=0xA5, SIN tied to SOUT, 8 consecutive SHIFT_EN -> SOUT sequence 1,0,1,0,0,1,0,1; Q=0xA5 at end; DONE high exactly one cycle; BUSY falls with it.
- Receive with gaps: LOAD 0x00, SIN drives 0x3C MSB-first, idle cycles between shifts -> Q=0x3C after the 8th shift; BUSY=1 throughout the gaps; DONE only after the 8th shift.
- Bit order: LOAD 0x01 with LSB_FIRST=1, SIN=0, one shift:
  - With macro: first SOUT=1, then Q=0x00.
  - Without macro: first SOUT=0, then Q=0x02.
- Priority/abort:
  - CLR and PRE on the same edge -> Q=0x00.
  - PRE after 3 of 8 shifts -> Q=0xFF, BUSY=0, no DONE pulse.
- Ignored inputs: LOAD 0x55 during SHIFTING -> Q and cnt unaffected. LOAD 0x55 with SHIFT_EN in IDLE -> Q=0x55, no shift. Back-to-back LOAD in the DONE cycle -> accepted.
